// File: rtl/itcm_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : itcm_resp_pkg
// Description : Shared widths, FSM state encodings and address helpers for
//               the instruction-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package itcm_resp_pkg;

    // Fetch-side widths shared with the rest of the core.
    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 32;

    // Word-index width for the default 4096-word array.
    localparam int ITCM_IDX_W  = 12;

    // Responder FSM state encodings.
    localparam logic [2:0] ITCM_IDLE = 3'd0;
    localparam logic [2:0] ITCM_WAIT = 3'd1;
    localparam logic [2:0] ITCM_READ = 3'd2;
    localparam logic [2:0] ITCM_ERR  = 3'd3;
    localparam logic [2:0] ITCM_RESP = 3'd4;

    // Outcome of classifying a byte address against the array window.
    typedef struct packed {
        logic misalign;
        logic bus_err;
    } itcm_class_t;

    // Byte offset of addr from base, one bit wider than the address so that
    // addresses below base produce a set top bit (and thus a huge offset).
    function automatic logic [PC_WIDTH:0] itcm_offset(
        input logic [PC_WIDTH-1:0] addr,
        input logic [PC_WIDTH-1:0] base
    );
        return {1'b0, addr} - {1'b0, base};
    endfunction

    // Misalignment wins over range: a misaligned address never reports a
    // bus error, whatever its range.
    function automatic itcm_class_t itcm_classify(
        input logic [1:0] low_bits,
        input logic       in_range
    );
        itcm_class_t c;
        c.misalign = |low_bits;
        c.bus_err  = ~(|low_bits) & ~in_range;
        return c;
    endfunction

endpackage : itcm_resp_pkg
`default_nettype wire

// File: rtl/itcm_resp_sram.sv
`default_nettype none
// ============================================================================
// Module      : itcm_sram_1r1w
// Description : Instruction SRAM, one synchronous read port and one write
//               port. A same-address read and write on one edge returns the
//               old word (read-before-write).
// Revision    : 1.0 - initial release
// ============================================================================
module itcm_sram_1r1w #(
    parameter int DEPTH_WORDS = 4096,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 12
) (
    input  logic              clk,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Array storage with registered read; the read register only moves on
    // re_i so the last word read stays on rdata_o until the next read.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule : itcm_sram_1r1w
`default_nettype wire

// File: rtl/itcm_resp.sv
`default_nettype none
// ============================================================================
// Module      : itcm_resp
// Description : Instruction-memory responder. Accepts one fetch address at a
//               time, classifies it (misaligned / out of window / legal),
//               inserts WAIT_CYCLES wait states for legal reads and returns
//               the instruction word or an error flag. Includes a word-write
//               load port for program preload.
// Revision    : 1.0 - initial release
// ============================================================================
module itcm_resp
    import itcm_resp_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] ADDR_BASE   = 32'h8000_0000,
    parameter int                  DEPTH_WORDS = 4096,
    parameter int                  WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [PC_WIDTH-1:0]    req_addr_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [INSTR_WIDTH-1:0] rsp_instr_o,
    output logic                   rsp_misalign_o,
    output logic                   rsp_bus_err_o,
    input  logic                   ld_en_i,
    input  logic [PC_WIDTH-1:0]    ld_addr_i,
    input  logic [INSTR_WIDTH-1:0] ld_wdata_i
);

    localparam int                c_IDX_W = $clog2(DEPTH_WORDS);
    // Size of the array window in bytes, at offset width.
    localparam logic [PC_WIDTH:0] c_SPAN  = (PC_WIDTH+1)'(DEPTH_WORDS) << 2;
    localparam logic [3:0]        c_WAIT  = 4'(WAIT_CYCLES);

    // ------------------------------------------------------------------
    // Address classification (fetch and load share the same window)
    // ------------------------------------------------------------------
    logic [PC_WIDTH:0]    w_req_off;
    logic                 w_req_in_range;
    itcm_class_t          w_req_class;
    logic [c_IDX_W-1:0]   w_req_idx;

    logic [PC_WIDTH:0]    w_ld_off;
    logic                 w_ld_in_range;
    itcm_class_t          w_ld_class;
    logic [c_IDX_W-1:0]   w_ld_idx;
    logic                 w_ld_we;

    assign w_req_off      = itcm_offset(req_addr_i, ADDR_BASE);
    assign w_req_in_range = (w_req_off < c_SPAN);
    assign w_req_class    = itcm_classify(req_addr_i[1:0], w_req_in_range);
    assign w_req_idx      = w_req_off[c_IDX_W+1:2];

    assign w_ld_off       = itcm_offset(ld_addr_i, ADDR_BASE);
    assign w_ld_in_range  = (w_ld_off < c_SPAN);
    assign w_ld_class     = itcm_classify(ld_addr_i[1:0], w_ld_in_range);
    assign w_ld_idx       = w_ld_off[c_IDX_W+1:2];
    // Bad load addresses are dropped without any indication.
    assign w_ld_we        = ld_en_i & ~w_ld_class.misalign & ~w_ld_class.bus_err;

    // ------------------------------------------------------------------
    // FSM state and request context
    // ------------------------------------------------------------------
    logic [2:0]         state_q,    state_d;
    logic [3:0]         cnt_q,      cnt_d;
    logic [c_IDX_W-1:0] idx_q,      idx_d;
    logic               misalign_q, misalign_d;
    logic               bus_err_q,  bus_err_d;

    logic               w_accept;
    logic               w_sram_re;
    logic [INSTR_WIDTH-1:0] w_sram_rdata;

    assign w_accept  = req_valid_i & (state_q == ITCM_IDLE);
    assign w_sram_re = (state_q == ITCM_READ);

    // Next-state logic: classify on accept, count wait states, then read or
    // report the error and hold the response until it is taken.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        misalign_d = misalign_q;
        bus_err_d  = bus_err_q;
        case (state_q)
            ITCM_IDLE: begin
                if (w_accept) begin
                    idx_d      = w_req_idx;
                    misalign_d = w_req_class.misalign;
                    bus_err_d  = w_req_class.bus_err;
                    if (w_req_class.misalign || w_req_class.bus_err) begin
                        state_d = ITCM_ERR;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = ITCM_READ;
                    end else begin
                        state_d = ITCM_WAIT;
                        cnt_d   = c_WAIT;
                    end
                end
            end
            ITCM_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ITCM_READ;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ITCM_READ: begin
                state_d = ITCM_RESP;
            end
            ITCM_ERR: begin
                state_d = ITCM_RESP;
            end
            ITCM_RESP: begin
                if (rsp_ready_i) begin
                    state_d    = ITCM_IDLE;
                    misalign_d = 1'b0;
                    bus_err_d  = 1'b0;
                end
            end
            default: begin
                state_d    = ITCM_IDLE;
                cnt_d      = 4'd0;
                misalign_d = 1'b0;
                bus_err_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any in-flight request or response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ITCM_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Instruction array
    // ------------------------------------------------------------------
    itcm_sram_1r1w #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (INSTR_WIDTH),
        .IDX_W       (c_IDX_W)
    ) u_sram (
        .clk     (clk),
        .re_i    (w_sram_re),
        .raddr_i (idx_q),
        .rdata_o (w_sram_rdata),
        .we_i    (w_ld_we),
        .waddr_i (w_ld_idx),
        .wdata_i (ld_wdata_i)
    );

    // ------------------------------------------------------------------
    // Outputs. The SRAM read register only updates in READ, so the word
    // shown during RESP cannot be disturbed by later loads.
    // ------------------------------------------------------------------
    assign req_ready_o    = (state_q == ITCM_IDLE);
    assign rsp_valid_o    = (state_q == ITCM_RESP);
    assign rsp_misalign_o = rsp_valid_o & misalign_q;
    assign rsp_bus_err_o  = rsp_valid_o & bus_err_q;
    assign rsp_instr_o    = (rsp_valid_o && !misalign_q && !bus_err_q) ? w_sram_rdata : '0;

endmodule : itcm_resp
`default_nettype wire

// File: doc/itcm_resp.md
Name: itcm_resp

Overview:
- Instruction-memory responder: the memory/bus-slave end of the instruction fetch interface.
- Accepts one fetch address at a time and returns the 32-bit instruction word, or a misalign or bus-error indication.
- Has a configurable number of wait states and a word-write load port for program preload by the testbench or debug.
- Sits between the fetch stage's bus adapter and on-chip instruction SRAM.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_WORDS, 4096, memory depth in 32-bit words; power of two, at least 2.
- WAIT_CYCLES, 1, extra cycles between accept and response for legal reads; range 0..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  fetch request valid.
- req_ready_o  out  1  responder can accept a request.
- req_addr_i  in  `PC_WIDTH  fetch byte address.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  requester accepts the response.
- rsp_instr_o  out  `INSTR_WIDTH  instruction word; 0 on error.
- rsp_misalign_o  out  1  req_addr_i[1:0] != 0.
- rsp_bus_err_o  out  1  aligned address outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS).
- ld_en_i  in  1  load-port word write enable.
- ld_addr_i  in  `PC_WIDTH  load byte address.
- ld_wdata_i  in  `INSTR_WIDTH  load data.

Behaviour:
- Reset values: state IDLE, wait counter 0, rsp_valid_o 0, rsp_instr_o 0, rsp_misalign_o 0, rsp_bus_err_o 0. req_ready_o is 1 in the cycle after rst deasserts. Memory contents are not reset.
- States:
  - IDLE: req_ready_o=1. On req_valid_i, latch the address and classify it.
    - Misaligned → ERR. Misalign takes priority; rsp_bus_err_o=0.
    - Out of range → ERR.
    - Legal, WAIT_CYCLES=0 → READ.
    - Legal, otherwise → WAIT with counter=WAIT_CYCLES.
  - WAIT: decrement the counter each cycle; at 1, go to READ.
  - READ: issue the synchronous SRAM read at index (addr-ADDR_BASE)>>2; go to RESP.
  - ERR: one cycle; go to RESP with rsp_instr_o=0 and the flag set.
  - RESP: rsp_valid_o=1, all outputs held stable. When rsp_ready_i=1, go to IDLE and drop rsp_valid_o next cycle.
- req_ready_o is 1 only in IDLE; a request is accepted only when req_valid_i && req_ready_o. Throughput is at most one fetch per (WAIT_CYCLES+3) cycles.
- Latency, request accepted at cycle T:
  - Legal read: rsp_valid_o=1 at T+2+WAIT_CYCLES.
  - Error: rsp_valid_o=1 at T+2.
- Range check uses a (`PC_WIDTH+1)-bit subtract; addresses that wrap below ADDR_BASE are out of range.
- Load port:
  - Writes in any state; out-of-range or misaligned ld_addr_i is silently ignored.
  - A write to the same word in the READ cycle returns old data (read-before-write).
  - A write during WAIT before READ is visible in the response.
  - A write after READ does not change the held rsp_instr_o.
- rst asserted in any state drops the pending request and response; no response is ever produced for it.
- req_valid_i or req_addr_i changing while not in IDLE is ignored.

Decomposition:
- defines.v gains `ITCM_IDX_W (clog2 of DEPTH_WORDS at default) and the state encodings `ITCM_IDLE, `ITCM_WAIT, `ITCM_READ, `ITCM_ERR, `ITCM_RESP (3 bits).
- One sub-module, itcm_sram_1r1w: DEPTH_WORDS x 32, one synchronous read port and one write port, read-before-write on address collision.
- FSM, counter, and address classification stay in itcm_resp.

Test Plan:
- Preload word 0x8000_0010 with 0x0000_0513 via ld_en_i, WAIT_CYCLES=1, request 0x8000_0010 at T → rsp_valid_o at T+3, rsp_instr_o=0x0000_0513, both flags 0.
- Request 0x8000_0002 → response at T+2, rsp_misalign_o=1, rsp_bus_err_o=0, rsp_instr_o=0.
- Request 0x8000_4000 (one past end at default depth) and request 0x7FFF_FFFC → each responds at T+2, rsp_bus_err_o=1, rsp_misalign_o=0.
- Hold rsp_ready_i=0 for 5 cycles in RESP → rsp_valid_o and data stable, req_ready_o=0 throughout; assert rsp_ready_i → req_ready_o=1 the next cycle.
- Load 0xDEAD_BEEF to the same word during WAIT → response 0xDEAD_BEEF. Load 0x1234_5678 in the READ cycle → response 0xDEAD_BEEF.
- Assert rst in the WAIT state → next cycle IDLE, rsp_valid_o=0, req_ready_o=1; no stale response appears afterwards.
